// File: rtl/onchip_memory2_arbiter_if.sv
// Avalon-style word port for one requester of the shared on-chip RAM.
// The requester drives command signals; the arbiter returns waitrequest and the read response.
interface onchip_memory2_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic              lock;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata, lock,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata, lock,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/onchip_memory2_arbiter.sv
// Two-requester arbiter for a single-port on-chip RAM with round-robin ties and lock support.
// Read latency 1 cycle; losers see waitrequest, out-of-range commands complete without RAM access.
module onchip_memory2_arbiter #(
    parameter int NUM_WORDS = 51200,
    parameter int ADDR_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    onchip_memory2_arbiter_if.slave m0,
    onchip_memory2_arbiter_if.slave m1,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [3:0]            mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [31:0]           mem_writedata,
    output logic                  mem_clken,
    input  logic [31:0]           mem_readdata
);
    typedef enum logic [1:0] {IDLE, LOCKED0, LOCKED1} state_t;

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_WORDS);

    state_t            state, state_nxt;
    logic              act0, act1, gnt0, gnt1, acc0, acc1, acc_any;
    logic              sel, sel_write, sel_oor, last_grant;
    logic [ADDR_W-1:0] sel_addr;
    logic              rsp_vld, rsp_owner, rsp_oor;

    // A simultaneous read+write is treated purely as a write.
    assign act0    = m0.read | m0.write;
    assign act1    = m1.read | m1.write;
    assign acc0    = act0 & gnt0 & ~reset;
    assign acc1    = act1 & gnt1 & ~reset;
    assign acc_any = acc0 | acc1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc0 && m0.lock)      state_nxt = LOCKED0;
                else if (acc1 && m1.lock) state_nxt = LOCKED1;
            end
            // Owner releases by an unlocked access or by dropping lock while idle.
            LOCKED0: if (!m0.lock && (acc0 || !act0)) state_nxt = IDLE;
            LOCKED1: if (!m1.lock && (acc1 || !act1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            LOCKED0: gnt0 = act0;
            LOCKED1: gnt1 = act1;
            default: begin
                if (act0 && act1) begin
                    gnt0 = last_grant;
                    gnt1 = ~last_grant;
                end else begin
                    gnt0 = act0;
                    gnt1 = act1;
                end
            end
        endcase
    end

    assign m0.waitrequest = ~reset & act0 & ~gnt0;
    assign m1.waitrequest = ~reset & act1 & ~gnt1;

    assign sel       = gnt1;
    assign sel_addr  = sel ? m1.address : m0.address;
    assign sel_write = sel ? m1.write : m0.write;
    assign sel_oor   = {1'b0, sel_addr} >= LIMIT;

    assign mem_address    = sel_addr;
    assign mem_chipselect = acc_any & ~sel_oor;
    assign mem_write      = mem_chipselect & sel_write;
    assign mem_byteenable = sel_write ? (sel ? m1.byteenable : m0.byteenable) : 4'hF;
    assign mem_writedata  = sel ? m1.writedata : m0.writedata;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            rsp_vld    <= 1'b0;
            rsp_owner  <= 1'b0;
            rsp_oor    <= 1'b0;
        end else begin
            rsp_vld <= acc_any & ~sel_write;
            if (acc_any) begin
                last_grant <= sel;
                rsp_owner  <= sel;
                rsp_oor    <= sel_oor;
            end
        end
    end

    // Readdata is forced to zero whenever the requester has no response this cycle.
    assign m0.readdatavalid = rsp_vld & ~rsp_owner;
    assign m1.readdatavalid = rsp_vld & rsp_owner;
    assign m0.readdata      = (m0.readdatavalid && !rsp_oor) ? mem_readdata : 32'h0;
    assign m1.readdata      = (m1.readdatavalid && !rsp_oor) ? mem_readdata : 32'h0;
endmodule

// File: tb/tb_onchip_memory2_arbiter.sv
// Directed bench for onchip_memory2_arbiter: a RAM model behind the arbiter, a response
// scoreboard checked on the falling edge, and combinational checks right after each drive.
module tb_onchip_memory2_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;

    onchip_memory2_arbiter_if #(.ADDR_W(16)) m0_if ();
    onchip_memory2_arbiter_if #(.ADDR_W(16)) m1_if ();

    onchip_memory2_arbiter #(.NUM_WORDS(51200), .ADDR_W(16)) dut (
        .clk(clk), .reset(reset), .m0(m0_if.slave), .m1(m1_if.slave),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: word i holds 0xC0DE0000|i after reset; read data valid one cycle later.
    logic [31:0] ram [0:65535];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 32'hC0DE0000 | 32'(i);
        end else if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_rd(input int owner, input logic [31:0] d);
        q.push_back('{owner, d, cyc + 1});
    endtask

    // Scoreboard monitor: every response must match the oldest expectation in owner, data and cycle.
    logic        mon_v;
    logic [31:0] mon_d;
    exp_t        mon_e;
    always @(negedge clk) begin
        for (int n = 0; n < 2; n++) begin
            mon_v = (n == 0) ? m0_if.readdatavalid : m1_if.readdatavalid;
            mon_d = (n == 0) ? m0_if.readdata : m1_if.readdata;
            n_vec++;
            if (mon_v === 1'b1) begin
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_rdv m%0d: got data %h at cycle %0d, expected none", n, mon_d, cyc);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.owner != n || mon_e.data !== mon_d || mon_e.due != cyc) begin
                        n_bad++;
                        $display("FAIL response m%0d: got data %h cycle %0d, expected m%0d data %h cycle %0d",
                                 n, mon_d, cyc, mon_e.owner, mon_e.data, mon_e.due);
                    end
                end
            end else if (mon_v !== 1'b0 || mon_d !== 32'h0) begin
                n_bad++;
                $display("FAIL idle_rdata m%0d: got valid %b data %h, expected 0/0", n, mon_v, mon_d);
            end
        end
    end

    task automatic drive0(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [3:0] be, input logic [31:0] d, input logic lk);
        m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
        m0_if.byteenable = be; m0_if.writedata = d; m0_if.lock = lk;
    endtask

    task automatic drive1(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [3:0] be, input logic [31:0] d, input logic lk);
        m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
        m1_if.byteenable = be; m1_if.writedata = d; m1_if.lock = lk;
    endtask

    task automatic idle_all();
        drive0(0, 0, 16'h0, 4'h0, 32'h0, 0);
        drive1(0, 0, 16'h0, 4'h0, 32'h0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_all();
        tick();
        // Requests during reset must see no waitrequest and cause no RAM access.
        drive0(0, 1, 16'h1, 4'hF, 32'h1, 0);
        drive1(1, 0, 16'h2, 4'hF, 32'h0, 0);
        #1;
        check("rst_m0_waitrequest", 32'(m0_if.waitrequest), 32'h0);
        check("rst_m1_waitrequest", 32'(m1_if.waitrequest), 32'h0);
        check("rst_chipselect", 32'(mem_chipselect), 32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_m0_readdata", m0_if.readdata, 32'h0);
        check("mem_clken", 32'(mem_clken), 32'h1);
        tick();
        idle_all();

        // Simultaneous reads after reset: m0 wins the first tie.
        tick();
        reset = 1'b0;
        drive0(1, 0, 16'h10, 4'h0, 32'h0, 0);
        drive1(1, 0, 16'h20, 4'h0, 32'h0, 0);
        #1;
        check("tie_m0_waitrequest", 32'(m0_if.waitrequest), 32'h0);
        check("tie_m1_waitrequest", 32'(m1_if.waitrequest), 32'h1);
        check("tie_mem_address", 32'(mem_address), 32'h10);
        check("tie_read_be", 32'(mem_byteenable), 32'hF);
        expect_rd(0, 32'hC0DE0010);
        tick();
        drive0(0, 0, 16'h0, 4'h0, 32'h0, 0);
        #1;
        check("m1_now_granted", 32'(m1_if.waitrequest), 32'h0);
        check("m1_mem_address", 32'(mem_address), 32'h20);
        expect_rd(1, 32'hC0DE0020);
        tick();
        idle_all();

        // Continuous writes from both: grants alternate 0,1,0,1, each with its own byteenable.
        tick();
        drive0(0, 1, 16'h40, 4'b0001, 32'h11111111, 0);
        drive1(0, 1, 16'h50, 4'b0010, 32'h22222222, 0);
        #1;
        check("wr0_grant_m1_wait", 32'(m1_if.waitrequest), 32'h1);
        check("wr0_mem", {mem_write, mem_byteenable, mem_address}, {1'b1, 4'b0001, 16'h40});
        tick();
        drive0(0, 1, 16'h41, 4'b0100, 32'h33333333, 0);
        #1;
        check("wr1_grant_m0_wait", 32'(m0_if.waitrequest), 32'h1);
        check("wr1_mem", {mem_write, mem_byteenable, mem_address}, {1'b1, 4'b0010, 16'h50});
        check("wr1_wdata", mem_writedata, 32'h22222222);
        tick();
        drive1(0, 1, 16'h51, 4'b1000, 32'h44444444, 0);
        #1;
        check("wr2_mem", {mem_write, mem_byteenable, mem_address}, {1'b1, 4'b0100, 16'h41});
        tick();
        drive0(0, 1, 16'h42, 4'b1111, 32'h55555555, 0);
        #1;
        check("wr3_mem", {mem_write, mem_byteenable, mem_address}, {1'b1, 4'b1000, 16'h51});
        check("wr3_m0_wait", 32'(m0_if.waitrequest), 32'h1);
        tick();
        idle_all();

        // Read back partial writes; m0 last so the next tie favours m1.
        drive1(1, 0, 16'h50, 4'h0, 32'h0, 0);
        expect_rd(1, 32'hC0DE2250);
        tick();
        idle_all();
        drive0(1, 0, 16'h40, 4'h0, 32'h0, 0);
        expect_rd(0, 32'hC0DE0011);
        tick();
        idle_all();

        // Locked read-modify-write by m1 blocks m0 for both accesses.
        drive0(1, 0, 16'h7, 4'h0, 32'h0, 0);
        drive1(0, 1, 16'h5, 4'b0011, 32'hA5A5A5A5, 1);
        #1;
        check("lock_wr_m0_wait", 32'(m0_if.waitrequest), 32'h1);
        check("lock_wr_mem", {mem_write, mem_byteenable, mem_address}, {1'b1, 4'b0011, 16'h5});
        tick();
        drive1(1, 0, 16'h5, 4'h0, 32'h0, 0);
        #1;
        check("lock_rd_m0_wait", 32'(m0_if.waitrequest), 32'h1);
        check("lock_rd_m1_wait", 32'(m1_if.waitrequest), 32'h0);
        expect_rd(1, 32'hC0DEA5A5);
        tick();
        drive1(0, 0, 16'h0, 4'h0, 32'h0, 0);
        #1;
        check("unlock_m0_granted", 32'(m0_if.waitrequest), 32'h0);
        expect_rd(0, 32'hC0DE0007);
        tick();
        idle_all();

        // Out-of-range read answers zero without chipselect; out-of-range write is dropped.
        drive0(1, 0, 16'hC800, 4'h0, 32'h0, 0);
        #1;
        check("oor_rd_chipselect", 32'(mem_chipselect), 32'h0);
        check("oor_rd_wait", 32'(m0_if.waitrequest), 32'h0);
        expect_rd(0, 32'h0);
        tick();
        drive0(0, 1, 16'hFFFF, 4'hF, 32'hDEADBEEF, 0);
        #1;
        check("oor_wr_mem_write", {mem_chipselect, mem_write}, 2'b00);
        tick();

        // Read and write together is a write with no response.
        drive0(1, 1, 16'h3, 4'hF, 32'h12345678, 0);
        #1;
        check("rw_mem_write", {mem_chipselect, mem_write}, 2'b11);
        tick();
        drive0(1, 0, 16'h3, 4'h0, 32'h0, 0);
        expect_rd(0, 32'h12345678);
        tick();

        // Read accepted, then reset asserted: response dropped, tie goes to m0 afterwards.
        drive0(1, 0, 16'h9, 4'h0, 32'h0, 0);
        tick();
        reset = 1'b1;
        idle_all();
        #1;
        check("rst_drop_rdv", 32'(m0_if.readdatavalid), 32'h0);
        tick();
        reset = 1'b0;
        drive0(1, 0, 16'h11, 4'h0, 32'h0, 0);
        drive1(1, 0, 16'h21, 4'h0, 32'h0, 0);
        #1;
        check("post_rst_m1_wait", 32'(m1_if.waitrequest), 32'h1);
        check("post_rst_m0_wait", 32'(m0_if.waitrequest), 32'h0);
        expect_rd(0, 32'hC0DE0011);
        tick();
        drive0(0, 0, 16'h0, 4'h0, 32'h0, 0);
        expect_rd(1, 32'hC0DE0021);
        tick();
        idle_all();

        for (int i = 0; i < 4; i++) tick();
        check("responses_outstanding", 32'(q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
